instr_encoder: RTL and testbench

- LEGv8 instruction encoder and instruction-memory loader: the inverse of the single-cycle opcode decoder.
- Accepts mnemonic-select plus register and immediate fields over a valid/ready request port, and packs them into 32-bit machine words.
- Buffers the words in a small FIFO and streams them to the instruction-memory write port at auto-incrementing byte addresses.
- Used by the test/boot infrastructure to build programs in hardware.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write handshake bundle for instr_encoder.
// The slave modport is the encoder's view and the master modport is the driver/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [25:0]       imm;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport slave (
        input  in_valid, op_sel, rd, rn, rm, imm, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

    modport master (
        output in_valid, op_sel, rd, rn, rm, imm, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: packs request fields into machine words, buffers them in a FIFO
// and streams them to instruction memory. Define IMM_RANGE_CHECK_EN to flag out-of-range immediates.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    bus,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [15:0]       words_written,
    output logic              err,
    input  logic              clr_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_ADDI = 4'd0;
    localparam logic [3:0] OP_ADDS = 4'd1;
    localparam logic [3:0] OP_B    = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd3;
    localparam logic [3:0] OP_CBZ  = 4'd4;
    localparam logic [3:0] OP_LDUR = 4'd5;
    localparam logic [3:0] OP_LSL  = 4'd6;
    localparam logic [3:0] OP_LSR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_STUR = 4'd9;
    localparam logic [3:0] OP_SUBS = 4'd10;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_SUBS);
    endfunction

    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [25:0] imm);
        logic [31:0] word;
        case (op)
            OP_ADDI: word = {10'b1001000100, imm[11:0], rn, rd};
            OP_ADDS: word = {11'b10101011000, rm, 6'b000000, rn, rd};
            OP_B:    word = {6'b000101, imm[25:0]};
            OP_BLT:  word = {8'b01010100, imm[18:0], 1'b0, 4'b1011};
            OP_CBZ:  word = {8'b10110100, imm[18:0], rd};
            OP_LDUR: word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            OP_LSL:  word = {11'b11010011011, 5'b00000, imm[5:0], rn, rd};
            OP_LSR:  word = {11'b11010011010, 5'b00000, imm[5:0], rn, rd};
            OP_MUL:  word = {11'b10011011000, rm, 6'b011111, rn, rd};
            OP_STUR: word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            OP_SUBS: word = {11'b11101011000, rm, 6'b000000, rn, rd};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // Signed fields fit when every bit above the field's sign bit matches it.
    function automatic logic imm_fits(input logic [3:0] op, input logic [25:0] imm);
        logic fits;
        case (op)
            OP_ADDI:                 fits = (imm[25:12] == 14'd0);
            OP_LSL, OP_LSR:          fits = (imm[25:6] == 20'd0);
            OP_BLT, OP_CBZ:          fits = (&imm[25:18]) | (~|imm[25:18]);
            OP_LDUR, OP_STUR:        fits = (&imm[25:8]) | (~|imm[25:8]);
            default:                 fits = 1'b1;
        endcase
        return fits;
    endfunction
`endif

    logic [31:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       words_r;
    logic              err_r;

    logic              accept_s;
    logic              range_bad_s;
    logic              bad_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       word_s;

    // Request decode: legality, optional immediate range check and the packed word.
    always_comb begin
`ifdef IMM_RANGE_CHECK_EN
        range_bad_s = ~imm_fits(bus.op_sel, bus.imm);
`else
        range_bad_s = 1'b0;
`endif
        accept_s = bus.in_valid & bus.in_ready;
        bad_s    = ~op_legal(bus.op_sel) | range_bad_s;
        push_s   = accept_s & ~bad_s;
        pop_s    = (count_r != CNT_W'(0)) & bus.wr_ready;
        word_s   = encode(bus.op_sel, bus.rd, bus.rn, bus.rm, bus.imm);
    end

    assign bus.in_ready   = reset & (count_r != CNT_W'(DEPTH));
    assign bus.wr_valid   = (count_r != CNT_W'(0));
    assign bus.wr_data    = mem_r[rd_ptr_r];
    assign bus.wr_addr    = addr_r;
    assign words_written  = words_r;
    assign err            = err_r;

    // FIFO storage, write address, completion counter and sticky error state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            addr_r   <= '0;
            words_r  <= 16'd0;
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                words_r  <= words_r + 16'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            // A load wins over the increment; a same-cycle write already used the old address.
            if (addr_load) begin
                addr_r <= base_addr;
            end else if (pop_s) begin
                addr_r <= addr_r + ADDR_W'(4);
            end
            if (accept_s & bad_s) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at accept time and
// matched against each completed memory write, with addresses tracked by a small model.
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       words_written;
    logic              err;
    logic              clr_err = 1'b0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .addr_load     (addr_load),
        .base_addr     (base_addr),
        .words_written (words_written),
        .err           (err),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [15:0]       exp_words = 16'd0;
    logic              hold_prev = 1'b0;
    logic [31:0]       hold_data = 32'd0;
    logic [ADDR_W-1:0] hold_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a rising edge; queues the word at the cycle it is accepted.
    task automatic send(input logic [3:0] op, input logic [4:0] rd_v, input logic [4:0] rn_v,
                        input logic [4:0] rm_v, input logic [25:0] imm_v,
                        input logic pushes, input logic [31:0] exp_word);
        logic done = 1'b0;
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.rd       = rd_v;
        bus.rn       = rn_v;
        bus.rm       = rm_v;
        bus.imm      = imm_v;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (pushes) exp_q.push_back(exp_word);
                done = 1'b1;
            end
        end
        check("accept_in_time", done, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Write monitor: compares each completed write and the running counters against the model.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            exp_q.delete();
            exp_addr  = '0;
            exp_words = 16'd0;
            hold_prev = 1'b0;
        end else begin
            check("words_written", words_written, exp_words);
            if (hold_prev) begin
                check("hold_data", bus.wr_data, hold_data);
                check("hold_addr", bus.wr_addr, hold_addr);
            end
            hold_prev = 1'b0;
            if (bus.wr_valid && bus.wr_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                check("wr_data", bus.wr_data, e);
                check("wr_addr", bus.wr_addr, exp_addr);
                exp_words = exp_words + 16'd1;
                exp_addr  = exp_addr + ADDR_W'(4);
            end else if (bus.wr_valid && !addr_load) begin
                hold_prev = 1'b1;
                hold_data = bus.wr_data;
                hold_addr = bus.wr_addr;
            end
            if (addr_load) exp_addr = base_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op_sel   = 4'd0;
        bus.rd       = 5'd0;
        bus.rn       = 5'd0;
        bus.rm       = 5'd0;
        bus.imm      = 26'd0;
        bus.wr_ready = 1'b1;

        @(negedge clk);
        check("in_ready_in_reset", bus.in_ready, 1'b0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_valid", bus.wr_valid, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 16'h0000);
        check("rst_wr_data", bus.wr_data, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);

        // ADDI with memory stalled: one-cycle latency, then completes once ready rises.
        tick();
        bus.wr_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd0, 26'd5, 1'b1, 32'h91001441);
        @(negedge clk);
        check("lat_wr_valid", bus.wr_valid, 1'b1);
        check("lat_wr_data", bus.wr_data, 32'h91001441);
        check("lat_wr_addr", bus.wr_addr, 16'h0000);
        tick();
        bus.wr_ready = 1'b1;
        tick();
        @(negedge clk);
        check("words_after_first", words_written, 16'd1);

        // Base address load followed by ADDS and SUBS.
        tick();
        addr_load = 1'b1;
        base_addr = 16'h0100;
        tick();
        addr_load = 1'b0;
        @(negedge clk);
        check("loaded_addr", bus.wr_addr, 16'h0100);
        tick();
        send(4'd1, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1, 32'hAB020023);
        send(4'd10, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1, 32'hEB020023);
        repeat (4) tick();

        // Fill the FIFO with memory stalled; the fifth request waits for a pop.
        bus.wr_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            send(4'd0, 5'(k), 5'd2, 5'd0, 26'd5, 1'b1, 32'h91001440 | 32'(k));
        end
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 1'b0);
        fork
            send(4'd0, 5'd4, 5'd2, 5'd0, 26'd5, 1'b1, 32'h91001444);
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready", bus.in_ready, 1'b0);
                tick();
                bus.wr_ready = 1'b1;
            end
        join
        repeat (10) tick();

        // Field packing across the remaining formats.
        send(4'd3, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b1, 32'h54FFFFEB);
        send(4'd4, 5'd7, 5'd0, 5'd0, 26'd3, 1'b1, 32'hB4000067);
        send(4'd5, 5'd4, 5'd5, 5'd0, 26'd8, 1'b1, 32'hF84080A4);
        send(4'd7, 5'd1, 5'd1, 5'd0, 26'd2, 1'b1, 32'hD3400821);
        send(4'd8, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1, 32'h9B027C23);
        send(4'd6, 5'd2, 5'd3, 5'd0, 26'd4, 1'b1, 32'hD3601062);
        send(4'd2, 5'd0, 5'd0, 5'd0, 26'h3FFFFFE, 1'b1, 32'h17FFFFFE);
        send(4'd9, 5'd6, 5'd7, 5'd0, 26'h3FFFFFD, 1'b1, 32'hF81FD0E6);
        repeat (8) tick();

        // Illegal selects: consumed without a write; a coinciding clear loses to the set.
        @(negedge clk);
        check("err_before_illegal", err, 1'b0);
        tick();
        send(4'd12, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("err_after_illegal", err, 1'b1);
        tick();
        clr_err = 1'b1;
        send(4'd15, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 32'h0);
        clr_err = 1'b0;
        @(negedge clk);
        check("err_set_beats_clr", err, 1'b1);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 1'b0);

        // Oversized ADDI immediate.
        tick();
`ifdef IMM_RANGE_CHECK_EN
        send(4'd0, 5'd1, 5'd2, 5'd0, 26'd4096, 1'b0, 32'h0);
        @(negedge clk);
        check("range_err", err, 1'b1);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
`else
        send(4'd0, 5'd1, 5'd2, 5'd0, 26'd4096, 1'b1, 32'h91000041);
        @(negedge clk);
        check("trunc_no_err", err, 1'b0);
        tick();
`endif
        repeat (4) tick();

        // Reset with three words buffered discards them.
        bus.wr_ready = 1'b0;
        send(4'd0, 5'd8, 5'd2, 5'd0, 26'd5, 1'b1, 32'h91001448);
        send(4'd0, 5'd9, 5'd2, 5'd0, 26'd5, 1'b1, 32'h91001449);
        send(4'd0, 5'd10, 5'd2, 5'd0, 26'd5, 1'b1, 32'h9100144A);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_valid", bus.wr_valid, 1'b0);
        check("midrst_words", words_written, 16'd0);
        check("midrst_wr_addr", bus.wr_addr, 16'h0000);
        tick();
        bus.wr_ready = 1'b1;
        repeat (5) tick();
        send(4'd4, 5'd7, 5'd0, 5'd0, 26'd3, 1'b1, 32'hB4000067);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        repeat (2) tick();
        check("drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
